// File: rtl/if_id_register.sv
// Fetch-to-decode pipeline register with flush/stall control, masked source-register
// decode for the hazard unit, and stall/flush performance counters.
module if_id_register #(
  parameter int          XLEN      = 32,
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction_IF,
  input  logic [XLEN-1:0]      PC_IF,
  input  logic [XLEN-1:0]      PCPlus4_IF,
  input  logic                 stall_ID,
  input  logic                 flush_ID,
  input  logic                 counterClear,
  output logic [31:0]          instruction_ID,
  output logic [XLEN-1:0]      PC_ID,
  output logic [XLEN-1:0]      PCPlus4_ID,
  output logic                 valid_ID,
  output logic [4:0]           readAddress1_ID,
  output logic [4:0]           readAddress2_ID,
  output logic [CNT_WIDTH-1:0] stallCount,
  output logic [CNT_WIDTH-1:0] flushCount
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] opcode;

  // IF -> ID stage boundary: flush beats stall, stall holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_ID <= NOP_INSTR;
      PC_ID          <= '0;
      PCPlus4_ID     <= '0;
      valid_ID       <= 1'b0;
    end else if (flush_ID) begin
      instruction_ID <= NOP_INSTR;
      PC_ID          <= '0;
      PCPlus4_ID     <= '0;
      valid_ID       <= 1'b0;
    end else if (!stall_ID) begin
      instruction_ID <= instruction_IF;
      PC_ID          <= PC_IF;
      PCPlus4_ID     <= PCPlus4_IF;
      valid_ID       <= 1'b1;
    end
  end

  // A stall cycle that is also flushed counts only as a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else if (counterClear) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (flush_ID) flushCount <= flushCount + CNT_WIDTH'(1);
      else if (stall_ID) stallCount <= stallCount + CNT_WIDTH'(1);
    end
  end

  // Decode from registered state only, so stall/flush never reach these outputs combinationally
  always_comb begin
    opcode          = instruction_ID[6:0];
    readAddress1_ID = 5'd0;
    readAddress2_ID = 5'd0;
    if (valid_ID) begin
      if (!(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL))
        readAddress1_ID = instruction_ID[19:15];
      if (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH)
        readAddress2_ID = instruction_ID[24:20];
    end
  end

endmodule

// File: tb/tb_if_id_register.sv
// Directed bench for if_id_register: an independent reference model pushes expected
// state per edge into a queue, which is popped and compared just after the edge.
module tb_if_id_register;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction_IF;
  logic [31:0]   PC_IF, PCPlus4_IF;
  logic          stall_ID, flush_ID, counterClear;
  logic [31:0]   instruction_ID;
  logic [31:0]   PC_ID, PCPlus4_ID;
  logic          valid_ID;
  logic [4:0]    readAddress1_ID, readAddress2_ID;
  logic [CW-1:0] stallCount, flushCount;

  if_id_register #(.XLEN(XLEN), .CNT_WIDTH(CW), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst),
    .instruction_IF(instruction_IF), .PC_IF(PC_IF), .PCPlus4_IF(PCPlus4_IF),
    .stall_ID(stall_ID), .flush_ID(flush_ID), .counterClear(counterClear),
    .instruction_ID(instruction_ID), .PC_ID(PC_ID), .PCPlus4_ID(PCPlus4_ID),
    .valid_ID(valid_ID), .readAddress1_ID(readAddress1_ID), .readAddress2_ID(readAddress2_ID),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [31:0]   pc4;
    logic          valid;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t expQ[$];
  exp_t model;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] refRs1(input logic [31:0] ins, input logic v);
    logic [6:0] op;
    op = ins[6:0];
    if (!v) return 5'd0;
    if (op == 7'h37 || op == 7'h17 || op == 7'h6F) return 5'd0;
    return ins[19:15];
  endfunction

  function automatic logic [4:0] refRs2(input logic [31:0] ins, input logic v);
    logic [6:0] op;
    op = ins[6:0];
    if (v && (op == 7'h33 || op == 7'h23 || op == 7'h63)) return ins[24:20];
    return 5'd0;
  endfunction

  task automatic modelReset();
    model.instr = 32'h00000013; model.pc = '0; model.pc4 = '0; model.valid = 1'b0;
    model.ra1 = '0; model.ra2 = '0; model.sc = '0; model.fc = '0;
  endtask

  task automatic compareAll(input string tag, input exp_t e);
    check({tag, ".instr"}, instruction_ID, e.instr);
    check({tag, ".pc"},    PC_ID,          e.pc);
    check({tag, ".pc4"},   PCPlus4_ID,     e.pc4);
    check({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, e.valid});
    check({tag, ".ra1"},   {27'd0, readAddress1_ID}, {27'd0, e.ra1});
    check({tag, ".ra2"},   {27'd0, readAddress2_ID}, {27'd0, e.ra2});
    check({tag, ".sc"},    {28'd0, stallCount}, {28'd0, e.sc});
    check({tag, ".fc"},    {28'd0, flushCount}, {28'd0, e.fc});
  endtask

  // Drive one cycle's inputs, update the model on the edge, compare 1ns after it
  task automatic cycle(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl, input logic clr);
    exp_t e;
    instruction_IF = ins; PC_IF = pc; PCPlus4_IF = pc + 32'd4;
    stall_ID = st; flush_ID = fl; counterClear = clr;
    @(posedge clk);
    if (fl) begin
      model.instr = 32'h00000013; model.pc = '0; model.pc4 = '0; model.valid = 1'b0;
    end else if (!st) begin
      model.instr = ins; model.pc = pc; model.pc4 = pc + 32'd4; model.valid = 1'b1;
    end
    if (clr) begin
      model.sc = '0; model.fc = '0;
    end else if (fl) model.fc = model.fc + 1'b1;
    else if (st) model.sc = model.sc + 1'b1;
    model.ra1 = refRs1(model.instr, model.valid);
    model.ra2 = refRs2(model.instr, model.valid);
    expQ.push_back(model);
    #1;
    if (expQ.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      compareAll(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    modelReset();
    r = model;
    rst = 1'b1; instruction_IF = 32'h00A00093; PC_IF = '0; PCPlus4_IF = 32'd4;
    stall_ID = 1'b0; flush_ID = 1'b0; counterClear = 1'b0;
    #1;
    compareAll("reset", r);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset then run
    cycle("run", 32'h00A00093, 32'h0, 1'b0, 1'b0, 1'b0);
    check("run.instrConst", instruction_ID, 32'h00A00093);
    check("run.validConst", {31'd0, valid_ID}, 32'd1);

    // load-use stall
    @(negedge clk);
    cycle("ldAdd", 32'h002081B3, 32'h10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cycle("stall1", 32'h00400113, 32'h14, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cycle("stall2", 32'h00800193, 32'h18, 1'b1, 1'b0, 1'b0);
    check("stall.instrConst", instruction_ID, 32'h002081B3);
    check("stall.pcConst", PC_ID, 32'h10);
    check("stall.ra1Const", {27'd0, readAddress1_ID}, 32'd1);
    check("stall.ra2Const", {27'd0, readAddress2_ID}, 32'd2);
    check("stall.scConst", {28'd0, stallCount}, 32'd2);

    // flush beats simultaneous stall
    @(negedge clk);
    cycle("flush", 32'h00C00213, 32'h1C, 1'b1, 1'b1, 1'b0);
    check("flush.instrConst", instruction_ID, 32'h00000013);
    check("flush.validConst", {31'd0, valid_ID}, 32'd0);
    check("flush.fcConst", {28'd0, flushCount}, 32'd1);
    check("flush.scConst", {28'd0, stallCount}, 32'd2);

    // address masking
    @(negedge clk);
    cycle("lui", 32'h123452B7, 32'h20, 1'b0, 1'b0, 1'b0);
    check("lui.ra1Const", {27'd0, readAddress1_ID}, 32'd0);
    @(negedge clk);
    cycle("sw", 32'h00532223, 32'h24, 1'b0, 1'b0, 1'b0);
    check("sw.ra1Const", {27'd0, readAddress1_ID}, 32'd6);
    check("sw.ra2Const", {27'd0, readAddress2_ID}, 32'd5);
    @(negedge clk);
    cycle("branch", 32'h00208463, 32'h28, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cycle("jal", 32'h008000EF, 32'h2C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cycle("auipc", 32'h00001517, 32'h30, 1'b0, 1'b0, 1'b0);

    // wrap and clear on a 4-bit counter
    @(negedge clk);
    cycle("clr0", 32'h0, 32'h34, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cycle("wrap", 32'hFFFF_FFFF, 32'h100 + i, 1'b1, 1'b0, 1'b0);
    end
    check("wrap.scConst", {28'd0, stallCount}, 32'd1);
    @(negedge clk);
    cycle("clrStall", 32'h0, 32'h200, 1'b1, 1'b0, 1'b1);
    check("clr.scConst", {28'd0, stallCount}, 32'd0);

    // async reset mid-stall
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cycle("preRst", 32'h00A00093, 32'h300, 1'b1, 1'b0, 1'b0);
    end
    check("preRst.scConst", {28'd0, stallCount}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    r = model;
    compareAll("asyncRst", r);
    @(negedge clk);
    rst = 1'b0;
    cycle("postRst", 32'h002081B3, 32'h40, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    cycle("postRst2", 32'h002081B3, 32'h40, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
# if_id_register

Fetch-to-decode pipeline register for the 5-stage core. It sits between the fetch stage and the decoder, and is the consumer of the hazard unit's `stall_ID` and `flush_ID` controls. It captures the fetched instruction and PC and inserts a NOP bubble on flush. It also derives the source-register addresses sent back to the hazard unit, masked so that formats with no rs1/rs2 field cannot cause a false stall. Two wrap-around counters record stall and flush cycles for performance analysis.

## Interface
Parameters:
- `XLEN`, 32, width of the PC and instruction datapath
- `CNT_WIDTH`, 32, width of each performance counter
- `NOP_INSTR`, 32'h00000013, bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  input  1  core clock; all state updates on its rising edge
- `rst`  input  1  asynchronous, active-high reset
- `instruction_IF`  input  32  instruction fetched this cycle
- `PC_IF`  input  XLEN  address of `instruction_IF`
- `PCPlus4_IF`  input  XLEN  `PC_IF` + 4
- `stall_ID`  input  1  hold the register contents
- `flush_ID`  input  1  load a bubble instead of `instruction_IF`
- `counterClear`  input  1  synchronous clear of both counters
- `instruction_ID`  output  32  registered instruction
- `PC_ID`  output  XLEN  registered PC
- `PCPlus4_ID`  output  XLEN  registered PC+4
- `valid_ID`  output  1  1 = real instruction, 0 = bubble or reset state
- `readAddress1_ID`  output  5  masked rs1 field, sent to the hazard unit
- `readAddress2_ID`  output  5  masked rs2 field, sent to the hazard unit
- `stallCount`  output  CNT_WIDTH  number of cycles held by stall
- `flushCount`  output  CNT_WIDTH  number of cycles flushed

## Operation
Register update, evaluated each rising `clk` edge in priority order:
- `flush_ID`=1: `instruction_ID`←`NOP_INSTR`, `PC_ID`←0, `PCPlus4_ID`←0, `valid_ID`←0. Flush wins over a simultaneous stall.
- else `stall_ID`=1: all registered fields keep their current values, including `valid_ID`.
- else: `instruction_ID`←`instruction_IF`, `PC_ID`←`PC_IF`, `PCPlus4_ID`←`PCPlus4_IF`, `valid_ID`←1.

Address decode is combinational from `instruction_ID`, with opcode `op` = bits [6:0]:
- `readAddress1_ID` = bits [19:15].
  - Forced to 0 when `op` is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - Forced to 0 when `valid_ID`=0.
- `readAddress2_ID` = bits [24:20] only when `op` is R-type (0110011), STORE (0100011) or BRANCH (1100011).
  - 0 in every other case, including `valid_ID`=0.

Counters:
- `stallCount` increments by 1 on each edge where `stall_ID`=1 and `flush_ID`=0.
- `flushCount` increments by 1 on each edge where `flush_ID`=1.
- Both counters wrap from all-ones to 0 and do not saturate.
- `counterClear`=1 sets both counters to 0 on that edge. Clear takes priority over a simultaneous increment.
- Counters keep counting while the pipeline is stalled.

## Timing
- Reset (asynchronous, takes effect immediately on `rst` assertion, no clock required):
  - `instruction_ID`=`NOP_INSTR`, `PC_ID`=0, `PCPlus4_ID`=0, `valid_ID`=0
  - `readAddress1_ID`=0, `readAddress2_ID`=0, `stallCount`=0, `flushCount`=0
- Latency: one cycle. A value on `instruction_IF` at edge N appears on `instruction_ID` after edge N.
- Stall of k consecutive cycles: outputs hold for k cycles. The next unstalled edge loads whatever is on `instruction_IF` at that edge. Fetch holds its own PC via `stall_IF`; this block does not latch a second entry.
- Flush on the same edge as stall: the result is a bubble, and only `flushCount` increments.
- Address outputs change only when `instruction_ID` or `valid_ID` changes, with no edge delay from them.
- If reset is asserted mid-stall or mid-flush, it overrides everything. The first edge after `rst` deasserts follows the normal priority rules.
- No combinational path from `stall_ID`/`flush_ID` to any output. This avoids a loop through the hazard unit.

## Test plan
- Reset then run: drive `rst`=1 with `instruction_IF`=32'h00A00093 (`addi x1,x0,10`) → outputs equal the reset values. Release `rst`; one edge later `instruction_ID`=32'h00A00093, `valid_ID`=1, `readAddress1_ID`=0, `readAddress2_ID`=0.
- Load-use stall: load `add x3,x1,x2` (32'h002081B3) at PC=0x10. Hold `stall_ID`=1 for 2 edges while `instruction_IF` changes → `instruction_ID` stays 32'h002081B3, `PC_ID`=0x10, `readAddress1_ID`=1, `readAddress2_ID`=2, and `stallCount`=2.
- Branch flush: with an instruction valid, assert `flush_ID`=1 and `stall_ID`=1 for one edge → `instruction_ID`=32'h00000013, `valid_ID`=0, both address outputs 0, `flushCount`=1, and `stallCount` unchanged.
- Masking: load LUI 32'h123452B7 → `readAddress1_ID`=0, `readAddress2_ID`=0. Load store `sw x5,4(x6)` 32'h00532223 → `readAddress1_ID`=6, `readAddress2_ID`=5.
- Counter wrap and clear: with `CNT_WIDTH`=4, stall for 17 edges → `stallCount`=1. Assert `counterClear` together with `stall_ID` for one edge → `stallCount`=0.
- Asynchronous reset mid-stall: assert `rst` between clock edges while `stall_ID`=1 and `stallCount`=3 → outputs go to reset values immediately, without waiting for an edge.
